// File: rtl/dma_request_pkg.sv
// ----------------------------------------------------------------------------
// dma_request_pkg : shared defaults, edge-mode constants and edge helper. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dma_request_pkg;

   localparam int DEFAULT_CHANNELS   = 4;
   localparam int DEFAULT_PEND_WIDTH = 2;

   localparam logic MODE_RISING  = 1'b0;
   localparam logic MODE_FALLING = 1'b1;

   function automatic logic edge_detect(input logic cur, input logic prev, input logic mode);
      return (mode == MODE_FALLING) ? (~cur & prev) : (cur & ~prev);
   endfunction

endpackage

`default_nettype wire

// File: rtl/dma_request_if.sv
// ----------------------------------------------------------------------------
// dma_request_if : DRQ/DACK/TC handshake between requesters and DMA controller. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface dma_request_if
   import dma_request_pkg::*;
#(
   parameter int CHANNELS = DEFAULT_CHANNELS
);

   logic [CHANNELS-1:0] dma_request;
   logic [CHANNELS-1:0] dma_acknowledge_n;
   logic                terminal_count_n;

   modport master (
      input  dma_request,
      output dma_acknowledge_n,
      output terminal_count_n
   );

   modport slave (
      output dma_request,
      input  dma_acknowledge_n,
      input  terminal_count_n
   );

endinterface

`default_nettype wire

// File: rtl/dma_request_channel.sv
// ----------------------------------------------------------------------------
// dma_request_channel : one channel's edge counter, service tracking and DRQ. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dma_request_channel
   import dma_request_pkg::*;
#(
   parameter int PEND_WIDTH = DEFAULT_PEND_WIDTH
) (
   input  wire logic                  clock,
   input  wire logic                  reset_n,
   input  wire logic                  trigger,
   input  wire logic                  trigger_enable,
   input  wire logic                  mode_falling,
   input  wire logic                  dma_acknowledge_n,
   input  wire logic                  terminal_count_n,
   input  wire logic                  overrun_clear,
   output logic                       dma_request,
   output logic [PEND_WIDTH-1:0]      pending,
   output logic                       overrun
);

   localparam logic [PEND_WIDTH-1:0] c_PEND_MAX = '1;
   localparam logic [PEND_WIDTH-1:0] c_PEND_ONE = PEND_WIDTH'(1);

   logic                  r_prev;
   logic                  r_armed;
   logic                  r_in_service;
   logic                  r_tc_seen;
   logic                  r_overrun;
   logic [PEND_WIDTH-1:0] r_pending;

   logic                  w_count;
   logic                  w_service_end;
   logic                  w_flush;
   logic                  w_saturate;
   logic                  w_tc_seen_next;
   logic                  w_overrun_next;
   logic [PEND_WIDTH-1:0] w_pending_next;

   assign w_count       = r_armed & trigger_enable & edge_detect(trigger, r_prev, mode_falling);
   assign w_service_end = r_in_service & dma_acknowledge_n;
   assign w_flush       = r_tc_seen | ~terminal_count_n;
   assign w_saturate    = w_count & ~w_service_end & (r_pending == c_PEND_MAX);

   // A counted edge coinciding with service end cancels the decrement, or
   // survives a TC flush as the single remaining request.
   always_comb begin
      w_pending_next = r_pending;
      if (w_service_end) begin
         if (w_flush) begin
            w_pending_next = w_count ? c_PEND_ONE : '0;
         end else if (!w_count && (r_pending != '0)) begin
            w_pending_next = r_pending - c_PEND_ONE;
         end
      end else if (w_count && (r_pending != c_PEND_MAX)) begin
         w_pending_next = r_pending + c_PEND_ONE;
      end
   end

   assign w_tc_seen_next = w_service_end ? 1'b0
                         : (r_tc_seen | (~terminal_count_n & ~dma_acknowledge_n));
   assign w_overrun_next = w_saturate | (r_overrun & ~overrun_clear);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_prev       <= 1'b0;
         r_armed      <= 1'b0;
         r_in_service <= 1'b0;
         r_tc_seen    <= 1'b0;
         r_overrun    <= 1'b0;
         r_pending    <= '0;
      end else begin
         r_prev       <= trigger;
         r_armed      <= 1'b1;
         r_in_service <= ~dma_acknowledge_n;
         r_tc_seen    <= w_tc_seen_next;
         r_overrun    <= w_overrun_next;
         r_pending    <= w_pending_next;
      end
   end

   assign dma_request = (r_pending != '0) & ~r_in_service;
   assign pending     = r_pending;
   assign overrun     = r_overrun;

endmodule

`default_nettype wire

// File: rtl/dma_request_controller.sv
// ----------------------------------------------------------------------------
// dma_request_controller : CHANNELS independent request channels sharing TC. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dma_request_controller
   import dma_request_pkg::*;
#(
   parameter int CHANNELS   = DEFAULT_CHANNELS,
   parameter int PEND_WIDTH = DEFAULT_PEND_WIDTH
) (
   input  wire logic                           clock,
   input  wire logic                           reset_n,
   input  wire logic [CHANNELS-1:0]            trigger,
   input  wire logic [CHANNELS-1:0]            trigger_enable,
   input  wire logic [CHANNELS-1:0]            mode_falling,
   input  wire logic [CHANNELS-1:0]            overrun_clear,
   output logic [CHANNELS*PEND_WIDTH-1:0]      pending_count,
   output logic [CHANNELS-1:0]                 overrun,
   dma_request_if.slave                        dma_bus
);

   logic [CHANNELS-1:0] w_dma_request;
   logic [CHANNELS-1:0] w_dma_acknowledge_n;
   logic                w_terminal_count_n;

   assign w_dma_acknowledge_n = dma_bus.dma_acknowledge_n;
   assign w_terminal_count_n  = dma_bus.terminal_count_n;
   assign dma_bus.dma_request = w_dma_request;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
      dma_request_channel #(
         .PEND_WIDTH (PEND_WIDTH)
      ) u_channel (
         .clock             (clock),
         .reset_n           (reset_n),
         .trigger           (trigger[i]),
         .trigger_enable    (trigger_enable[i]),
         .mode_falling      (mode_falling[i]),
         .dma_acknowledge_n (w_dma_acknowledge_n[i]),
         .terminal_count_n  (w_terminal_count_n),
         .overrun_clear     (overrun_clear[i]),
         .dma_request       (w_dma_request[i]),
         .pending           (pending_count[i*PEND_WIDTH +: PEND_WIDTH]),
         .overrun           (overrun[i])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_dma_request_controller.sv
// ----------------------------------------------------------------------------
// tb_dma_request_controller : vector table plus directed sequences, 8 channels. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dma_request_controller;
   import dma_request_pkg::*;

   localparam int CH = 8;
   localparam int PW = 2;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic [CH-1:0]     trigger;
   logic [CH-1:0]     trigger_enable;
   logic [CH-1:0]     mode_falling;
   logic [CH-1:0]     overrun_clear;
   logic [CH*PW-1:0]  pending_count;
   logic [CH-1:0]     overrun;

   dma_request_if #(.CHANNELS(CH)) dma_bus ();

   dma_request_controller #(
      .CHANNELS   (CH),
      .PEND_WIDTH (PW)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .trigger        (trigger),
      .trigger_enable (trigger_enable),
      .mode_falling   (mode_falling),
      .overrun_clear  (overrun_clear),
      .pending_count  (pending_count),
      .overrun        (overrun),
      .dma_bus        (dma_bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0]  trig;
      logic [7:0]  en;
      logic [7:0]  mode;
      logic [7:0]  dack_n;
      logic        tc_n;
      logic [7:0]  oclr;
      logic [7:0]  drq;
      logic [15:0] pend;
      logic [7:0]  ovr;
   } vec_t;

   typedef struct {
      logic [7:0]  drq;
      logic [15:0] pend;
      logic [7:0]  ovr;
      int          tag;
   } exp_t;

   exp_t exp_q[$];
   vec_t vt[45];
   int   total = 0;
   int   bad   = 0;
   int   tag   = 0;

   // Channel-0-only vector: other channels idle, disabled, DACK released.
   function automatic vec_t mk(logic t, logic d, logic tc, logic oc, logic en,
                               logic drq, logic [1:0] p, logic ov);
      vec_t v;
      v.trig   = {7'b0, t};
      v.en     = {7'b0, en};
      v.mode   = 8'h00;
      v.dack_n = {7'h7F, d};
      v.tc_n   = tc;
      v.oclr   = {7'b0, oc};
      v.drq    = {7'b0, drq};
      v.pend   = {14'b0, p};
      v.ovr    = {7'b0, ov};
      return v;
   endfunction

   task automatic check(input string what, input int t, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s #%0d got=%h want=%h", what, t, got, want);
      end
   endtask

   task automatic drive(input logic [7:0] trig, input logic [7:0] en, input logic [7:0] mode,
                        input logic [7:0] dack_n, input logic tc_n, input logic [7:0] oclr);
      trigger                   = trig;
      trigger_enable            = en;
      mode_falling              = mode;
      dma_bus.dma_acknowledge_n = dack_n;
      dma_bus.terminal_count_n  = tc_n;
      overrun_clear             = oclr;
   endtask

   task automatic step(input logic [7:0] trig, input logic [7:0] en, input logic [7:0] mode,
                       input logic [7:0] dack_n, input logic tc_n, input logic [7:0] oclr,
                       input logic [7:0] e_drq, input logic [15:0] e_pend, input logic [7:0] e_ovr);
      exp_t e;
      drive(trig, en, mode, dack_n, tc_n, oclr);
      e.drq  = e_drq;
      e.pend = e_pend;
      e.ovr  = e_ovr;
      e.tag  = tag;
      exp_q.push_back(e);
      tag++;
      @(posedge clock);
      #1;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_empty #%0d got=0 want=1", tag);
      end else begin
         e = exp_q.pop_front();
         check("drq",  e.tag, 32'(dma_bus.dma_request), 32'(e.drq));
         check("pend", e.tag, 32'(pending_count),       32'(e.pend));
         check("ovr",  e.tag, 32'(overrun),             32'(e.ovr));
      end
   endtask

   task automatic check_zero(input string what);
      check({what, "_drq"},  tag, 32'(dma_bus.dma_request), 32'h0);
      check({what, "_pend"}, tag, 32'(pending_count),       32'h0);
      check({what, "_ovr"},  tag, 32'(overrun),             32'h0);
   endtask

   task automatic apply_reset(input logic [7:0] trig, input logic [7:0] en, input logic [7:0] mode);
      drive(trig, en, mode, 8'hFF, 1'b1, 8'h00);
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check_zero("reset");
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog #%0d got=timeout want=finish", tag);
      $fatal(1, "watchdog expired");
   end

   initial begin
      //          t  d  tc oc en  drq p  ov
      vt[0]  = mk(0, 1, 1, 0, 1,  0, 0, 0);
      vt[1]  = mk(1, 1, 1, 0, 1,  1, 1, 0);
      vt[2]  = mk(1, 1, 1, 0, 1,  1, 1, 0);
      vt[3]  = mk(1, 0, 1, 0, 1,  0, 1, 0);
      vt[4]  = mk(1, 0, 1, 0, 1,  0, 1, 0);
      vt[5]  = mk(1, 1, 1, 0, 1,  0, 0, 0);
      vt[6]  = mk(0, 1, 1, 0, 1,  0, 0, 0);
      vt[7]  = mk(1, 1, 1, 0, 1,  1, 1, 0);
      vt[8]  = mk(0, 1, 1, 0, 1,  1, 1, 0);
      vt[9]  = mk(1, 1, 1, 0, 1,  1, 2, 0);
      vt[10] = mk(0, 1, 1, 0, 1,  1, 2, 0);
      vt[11] = mk(1, 1, 1, 0, 1,  1, 3, 0);
      vt[12] = mk(0, 1, 1, 0, 1,  1, 3, 0);
      vt[13] = mk(1, 1, 1, 0, 1,  1, 3, 1);
      vt[14] = mk(0, 1, 1, 0, 1,  1, 3, 1);
      vt[15] = mk(1, 1, 1, 0, 1,  1, 3, 1);
      vt[16] = mk(1, 1, 1, 1, 1,  1, 3, 0);
      vt[17] = mk(0, 1, 1, 0, 1,  1, 3, 0);
      vt[18] = mk(1, 1, 1, 1, 1,  1, 3, 1);
      vt[19] = mk(1, 1, 1, 1, 1,  1, 3, 0);
      vt[20] = mk(1, 0, 1, 0, 1,  0, 3, 0);
      vt[21] = mk(1, 1, 1, 0, 1,  1, 2, 0);
      vt[22] = mk(1, 0, 0, 0, 1,  0, 2, 0);
      vt[23] = mk(1, 1, 1, 0, 1,  0, 0, 0);
      vt[24] = mk(0, 1, 1, 0, 1,  0, 0, 0);
      vt[25] = mk(1, 1, 1, 0, 1,  1, 1, 0);
      vt[26] = mk(0, 1, 1, 0, 1,  1, 1, 0);
      vt[27] = mk(1, 1, 1, 0, 1,  1, 2, 0);
      vt[28] = mk(1, 0, 0, 0, 1,  0, 2, 0);
      vt[29] = mk(0, 0, 1, 0, 1,  0, 2, 0);
      vt[30] = mk(1, 1, 1, 0, 1,  1, 1, 0);
      vt[31] = mk(0, 0, 1, 0, 1,  0, 1, 0);
      vt[32] = mk(1, 1, 1, 0, 1,  1, 1, 0);
      vt[33] = mk(1, 0, 1, 0, 1,  0, 1, 0);
      vt[34] = mk(1, 1, 1, 0, 1,  0, 0, 0);
      vt[35] = mk(1, 0, 1, 0, 1,  0, 0, 0);
      vt[36] = mk(1, 1, 1, 0, 1,  0, 0, 0);
      vt[37] = mk(0, 1, 1, 0, 1,  0, 0, 0);
      vt[38] = mk(1, 1, 1, 0, 1,  1, 1, 0);
      vt[39] = mk(0, 1, 1, 0, 1,  1, 1, 0);
      vt[40] = mk(1, 1, 1, 0, 1,  1, 2, 0);
      vt[41] = mk(1, 0, 1, 0, 1,  0, 2, 0);
      vt[42] = mk(1, 1, 0, 0, 1,  0, 0, 0);
      vt[43] = mk(0, 1, 1, 0, 0,  0, 0, 0);
      vt[44] = mk(1, 1, 1, 0, 0,  0, 0, 0);

      apply_reset(8'h00, 8'h00, 8'h00);

      // Channel 0, rising mode: latency, service, saturation, overrun, TC flush, spurious DACK.
      for (int i = 0; i < 45; i++) begin
         step(vt[i].trig, vt[i].en, vt[i].mode, vt[i].dack_n, vt[i].tc_n, vt[i].oclr,
              vt[i].drq, vt[i].pend, vt[i].ovr);
      end

      // Reset asserted between clocks while channel 0 holds 3 and is in service.
      step(8'h00, 8'h01, 8'h00, 8'hFF, 1'b1, 8'h00, 8'h00, 16'h0000, 8'h00);
      step(8'h01, 8'h01, 8'h00, 8'hFF, 1'b1, 8'h00, 8'h01, 16'h0001, 8'h00);
      step(8'h00, 8'h01, 8'h00, 8'hFF, 1'b1, 8'h00, 8'h01, 16'h0001, 8'h00);
      step(8'h01, 8'h01, 8'h00, 8'hFF, 1'b1, 8'h00, 8'h01, 16'h0002, 8'h00);
      step(8'h00, 8'h01, 8'h00, 8'hFF, 1'b1, 8'h00, 8'h01, 16'h0002, 8'h00);
      step(8'h01, 8'h01, 8'h00, 8'hFF, 1'b1, 8'h00, 8'h01, 16'h0003, 8'h00);
      step(8'h01, 8'h01, 8'h00, 8'hFE, 1'b1, 8'h00, 8'h00, 16'h0003, 8'h00);
      reset_n = 1'b0;
      #1;
      check_zero("async_reset");
      #2;
      reset_n = 1'b1;
      step(8'h01, 8'h01, 8'h00, 8'hFF, 1'b1, 8'h00, 8'h00, 16'h0000, 8'h00);
      step(8'h01, 8'h01, 8'h00, 8'hFF, 1'b1, 8'h00, 8'h00, 16'h0000, 8'h00);

      // Ch0 rising with trigger high across release (must not count); ch1 falling mode.
      apply_reset(8'h01, 8'h03, 8'h02);
      step(8'h01, 8'h03, 8'h02, 8'hFF, 1'b1, 8'h00, 8'h00, 16'h0000, 8'h00);
      step(8'h01, 8'h03, 8'h02, 8'hFF, 1'b1, 8'h00, 8'h00, 16'h0000, 8'h00);
      step(8'h03, 8'h03, 8'h02, 8'hFF, 1'b1, 8'h00, 8'h00, 16'h0000, 8'h00);
      step(8'h01, 8'h03, 8'h02, 8'hFF, 1'b1, 8'h00, 8'h02, 16'h0004, 8'h00);
      step(8'h03, 8'h01, 8'h02, 8'hFF, 1'b1, 8'h00, 8'h02, 16'h0004, 8'h00);
      step(8'h01, 8'h01, 8'h02, 8'hFF, 1'b1, 8'h00, 8'h02, 16'h0004, 8'h00);

      // All eight channels edge together; ch3 alone is in service and ends service on that edge.
      apply_reset(8'h00, 8'hFF, 8'h00);
      step(8'h00, 8'hFF, 8'h00, 8'hFF, 1'b1, 8'h00, 8'h00, 16'h0000, 8'h00);
      step(8'hFF, 8'hFF, 8'h00, 8'hFF, 1'b1, 8'h00, 8'hFF, 16'h5555, 8'h00);
      step(8'h00, 8'hFF, 8'h00, 8'hF7, 1'b1, 8'h00, 8'hF7, 16'h5555, 8'h00);
      step(8'hFF, 8'hFF, 8'h00, 8'hFF, 1'b1, 8'h00, 8'hFF, 16'hAA6A, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
